// File: rtl/data_sram_like_bridge_pkg.sv
// Shared types for the data-side SRAM-like bridge: FSM state encoding,
// bus size codes and the kseg0/kseg1 address test.
package data_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [31:0] KSEG_MASK = 32'h1FFF_FFFF;

  // kseg0 and kseg1 together span 0x8000_0000..0xBFFF_FFFF (top bits 2'b10).
  function automatic logic is_kseg01(input logic [31:0] vaddr);
    return vaddr[31:30] == 2'b10;
  endfunction

endpackage

// File: rtl/data_sram_like_bridge_if.sv
// SRAM-like data bus. The bridge (master) holds data_req high for as long
// as the request is outstanding, with data_wr/size/addr/wdata stable; the
// request is accepted in the cycle where data_req and data_addr_ok are both
// high. Afterwards data_data_ok is a single-cycle pulse meaning read data on
// data_rdata is valid (read) or the write has completed (write); it may
// coincide with the accepting cycle.
interface data_sram_like_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_like_bridge_addr_map.sv
// Virtual-to-physical mapping for unmapped kernel segments: kseg0/kseg1
// addresses lose their top three bits, everything else passes through.
module data_sram_like_bridge_addr_map
  import data_sram_like_bridge_pkg::*;
#(
  parameter logic MAP_KSEG = 1'b1
) (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);

  assign paddr = (MAP_KSEG && is_kseg01(vaddr)) ? (vaddr & KSEG_MASK) : vaddr;

endmodule

// File: rtl/data_sram_like_bridge.sv
// Converts one MEM-stage load/store into one SRAM-like bus transaction,
// stalls the pipeline until it completes, and holds the load word in DONE
// until the pipeline advances so the access is never issued twice.
module data_sram_like_bridge
  import data_sram_like_bridge_pkg::*;
#(
  parameter logic MAP_KSEG = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_rd,
  input  logic [3:0]              mem_wen,
  input  logic [1:0]              mem_size,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic                    mem_exc,
  input  logic                    flush,
  input  logic                    longest_stall,
  output logic [31:0]             mem_rdata,
  output logic                    mem_stall,
  data_sram_like_bridge_if.master bus,
  output state_t                  dbg_state
);

  state_t      state, state_next;
  logic        acc;
  logic [31:0] paddr;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  data_sram_like_bridge_addr_map #(.MAP_KSEG(MAP_KSEG)) u_addr_map (
    .vaddr (mem_addr),
    .paddr (paddr)
  );

  // An access starts only for a live load/store that is not faulting or flushed.
  assign acc = (mem_rd | (|mem_wen)) & ~mem_exc & ~flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; an issued transaction always runs to DONE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (acc) state_next = ST_REQ;
      ST_REQ: begin
        if (bus.data_addr_ok && bus.data_data_ok) state_next = ST_DONE;
        else if (bus.data_addr_ok)                state_next = ST_WAIT;
      end
      ST_WAIT: if (bus.data_data_ok) state_next = ST_DONE;
      ST_DONE: if (!longest_stall || flush) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields are latched at start; the load word is captured on data_ok.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= 1'b0;
      size_q    <= SIZE_B;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc) begin
            wr_q    <= |mem_wen;
            size_q  <= mem_size;
            addr_q  <= paddr;
            wdata_q <= mem_wdata;
          end
        end
        ST_REQ: begin
          if (bus.data_addr_ok && bus.data_data_ok && !wr_q) mem_rdata <= bus.data_rdata;
        end
        ST_WAIT: begin
          if (bus.data_data_ok && !wr_q) mem_rdata <= bus.data_rdata;
        end
        default: ;
      endcase
    end
  end

  // data_req is a pure state decode so no input reaches it combinationally.
  assign bus.data_req   = (state == ST_REQ);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;

  assign mem_stall = ((state == ST_IDLE) && acc) || (state == ST_REQ) || (state == ST_WAIT);
  assign dbg_state = state;

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Directed bench for data_sram_like_bridge: a table of single accesses with
// a scripted bus slave, then hand-written flush, exception and reset cases.
module tb_data_sram_like_bridge;
  import data_sram_like_bridge_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_exc;
  logic        flush;
  logic        longest_stall;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  state_t      dbg_state;

  data_sram_like_bridge_if bus ();

  data_sram_like_bridge #(.MAP_KSEG(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_rd        (mem_rd),
    .mem_wen       (mem_wen),
    .mem_size      (mem_size),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_exc       (mem_exc),
    .flush         (flush),
    .longest_stall (longest_stall),
    .mem_rdata     (mem_rdata),
    .mem_stall     (mem_stall),
    .bus           (bus.master),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // aok: request cycles before addr_ok; dok: WAIT cycles until data_ok (0 = with addr_ok)
  typedef struct {
    logic        rd;
    logic [3:0]  wen;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          aok;
    int          dok;
    int          hold;
    logic [31:0] exp_addr;
    logic        exp_wr;
    int          exp_req;
    int          exp_done;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  // driver: one access with a scripted slave; entered and left at posedge+1
  task automatic do_access(input vec_t v);
    int cyc;
    int reqc;
    int waitc;
    int done_at;
    logic fields_checked;
    logic [31:0] held;
    mem_rd = v.rd; mem_wen = v.wen; mem_size = v.size;
    mem_addr = v.addr; mem_wdata = v.wdata;
    mem_exc = 1'b0; flush = 1'b0; longest_stall = 1'b1;
    reqc = 0; waitc = 0; done_at = -1; fields_checked = 1'b0;
    for (cyc = 0; cyc < 40 && done_at < 0; cyc++) begin
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
      #1;
      if (dbg_state == ST_DONE) begin
        done_at = cyc;
      end else begin
        chk("stall_busy", mem_stall, 1);
        if (bus.data_req) begin
          if (!fields_checked) begin
            chk("req_addr", bus.data_addr, v.exp_addr);
            chk("req_wr", bus.data_wr, v.exp_wr);
            chk("req_size", bus.data_size, v.size);
            chk("req_wdata", bus.data_wdata, v.wdata);
            fields_checked = 1'b1;
          end
          if (reqc >= v.aok) begin
            bus.data_addr_ok = 1'b1;
            if (v.dok == 0) begin bus.data_data_ok = 1'b1; bus.data_rdata = v.rdata; end
          end
          reqc++;
        end else if (dbg_state == ST_WAIT) begin
          waitc++;
          if (waitc >= v.dok) begin bus.data_data_ok = 1'b1; bus.data_rdata = v.rdata; end
        end
      end
      if (done_at < 0) begin @(posedge clk); #1; end
    end
    if (done_at < 0) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_latency", done_at, v.exp_done);
      chk("req_cycles", reqc, v.exp_req);
      chk("done_rdata", mem_rdata, v.exp_rdata);
      chk("done_stall", mem_stall, 0);
      chk("done_req", bus.data_req, 0);
    end
    held = mem_rdata;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #2;
      chk("hold_state", dbg_state, ST_DONE);
      chk("hold_req", bus.data_req, 0);
      chk("hold_rdata", mem_rdata, held);
      chk("hold_stall", mem_stall, 0);
    end
    longest_stall = 1'b0;
    @(posedge clk); #1;
    mem_rd = 1'b0; mem_wen = 4'h0;
    #1;
    chk("release_state", dbg_state, ST_IDLE);
    chk("release_req", bus.data_req, 0);
    chk("release_rdata", mem_rdata, v.exp_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    // rd wen size addr wdata rdata aok dok hold exp_addr exp_wr exp_req exp_done exp_rdata
    vecs[0] = '{1'b1, 4'h0, SIZE_W, 32'h8000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1, 2, 0,
                32'h0000_0010, 1'b0, 2, 5, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 4'b0100, SIZE_B, 32'hBFC0_0006, 32'h5A5A_5A5A, 32'h1111_1111, 0, 0, 0,
                32'h1FC0_0006, 1'b1, 1, 2, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 4'h0, SIZE_H, 32'hBFFF_FFFE, 32'h0000_0000, 32'h1234_CAFE, 0, 0, 3,
                32'h1FFF_FFFE, 1'b0, 1, 2, 32'h1234_CAFE};
    vecs[3] = '{1'b1, 4'h0, SIZE_W, 32'h7FFF_FFFC, 32'h0000_0000, 32'hA5A5_0001, 2, 1, 0,
                32'h7FFF_FFFC, 1'b0, 3, 5, 32'hA5A5_0001};
    vecs[4] = '{1'b0, 4'hF, SIZE_W, 32'hC000_0004, 32'h0123_4567, 32'hFFFF_FFFF, 0, 2, 2,
                32'hC000_0004, 1'b1, 1, 4, 32'hA5A5_0001};
    vecs[5] = '{1'b1, 4'h0, SIZE_B, 32'h0040_0003, 32'h0000_0000, 32'h0000_0077, 3, 0, 0,
                32'h0040_0003, 1'b0, 4, 5, 32'h0000_0077};

    rst = 1'b1; mem_rd = 1'b0; mem_wen = 4'h0; mem_size = 2'd0; mem_addr = 32'h0;
    mem_wdata = 32'h0; mem_exc = 1'b0; flush = 1'b0; longest_stall = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_addr", bus.data_addr, 32'h0);
    chk("rst_wdata", bus.data_wdata, 32'h0);
    chk("rst_size", bus.data_size, 2'd0);
    chk("rst_wr", bus.data_wr, 0);
    chk("rst_req", bus.data_req, 0);
    chk("rst_stall", mem_stall, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) do_access(vecs[i]);

    // exception suppresses the access
    mem_rd = 1'b1; mem_size = SIZE_W; mem_addr = 32'h8000_0040; mem_exc = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("exc_stall", mem_stall, 0);
      @(posedge clk); #1;
      chk("exc_req", bus.data_req, 0);
      chk("exc_state", dbg_state, ST_IDLE);
    end
    mem_rd = 1'b0; mem_exc = 1'b0;

    // flush during WAIT: transaction still completes, flushed instruction not reissued
    mem_rd = 1'b1; mem_size = SIZE_W; mem_addr = 32'h8000_0100; longest_stall = 1'b1;
    @(posedge clk); #2;
    chk("fl_req", bus.data_req, 1);
    chk("fl_addr", bus.data_addr, 32'h0000_0100);
    bus.data_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0; flush = 1'b1;
    #1;
    chk("fl_wait1", dbg_state, ST_WAIT);
    chk("fl_wait1_stall", mem_stall, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("fl_wait2", dbg_state, ST_WAIT);
    chk("fl_wait2_req", bus.data_req, 0);
    @(posedge clk); #1;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hF00D_F00D;
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    #1;
    chk("fl_done", dbg_state, ST_DONE);
    chk("fl_rdata", mem_rdata, 32'hF00D_F00D);
    flush = 1'b1;
    @(posedge clk); #2;
    chk("fl_idle", dbg_state, ST_IDLE);
    chk("fl_idle_stall", mem_stall, 0);
    @(posedge clk); #1;
    chk("fl_no_reissue_state", dbg_state, ST_IDLE);
    chk("fl_no_reissue_req", bus.data_req, 0);
    mem_rd = 1'b0; flush = 1'b0; longest_stall = 1'b0;
    #1;
    chk("fl_rdata_held", mem_rdata, 32'hF00D_F00D);
    @(posedge clk); #1;

    // reset while the request is outstanding
    mem_rd = 1'b1; mem_size = SIZE_W; mem_addr = 32'h0000_0200; longest_stall = 1'b1;
    @(posedge clk); #2;
    chk("rr_req_before", bus.data_req, 1);
    rst = 1'b1; mem_rd = 1'b0;
    @(posedge clk); #2;
    chk("rr_req", bus.data_req, 0);
    chk("rr_rdata", mem_rdata, 32'h0);
    chk("rr_state", dbg_state, ST_IDLE);
    chk("rr_addr", bus.data_addr, 32'h0);
    rst = 1'b0; longest_stall = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
